// File: rtl/rv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: datapath widths, load funct3
// codes, FSM states and the payload captured from X.
package rv_writeback_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned FUN_W  = 3;
    localparam int unsigned ALSB_W = 2;

    // Load funct3 encodings
    localparam logic [FUN_W-1:0] FUN_LB  = 3'b000;
    localparam logic [FUN_W-1:0] FUN_LH  = 3'b001;
    localparam logic [FUN_W-1:0] FUN_LW  = 3'b010;
    localparam logic [FUN_W-1:0] FUN_LBU = 3'b100;
    localparam logic [FUN_W-1:0] FUN_LHU = 3'b101;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } wb_state_e;

    // Instruction result held by W after acceptance from X
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [XLEN-1:0]   value;
        logic              write;
        logic [FUN_W-1:0]  fun;
        logic [ALSB_W-1:0] addr;
    } x_entry_t;

endpackage

// File: rtl/rv_writeback_if.sv
// X/data-memory/regfile signal bundle around the writeback stage.
// slave : writeback stage (consumes X + memory, drives stall, regfile, bypass)
// master: surrounding pipeline / testbench
interface rv_writeback_if;
    import rv_writeback_pkg::*;

    logic              x_valid_i;
    logic [REG_W-1:0]  x_rd_i;
    logic [XLEN-1:0]   x_rd_value_i;
    logic              x_rd_write_i;
    logic              x_load_i;
    logic [FUN_W-1:0]  x_fun_i;
    logic [ALSB_W-1:0] x_dm_addr_i;
    logic [XLEN-1:0]   dm_data_l_i;
    logic              dm_load_done_i;
    logic              w_stall_o;
    logic [REG_W-1:0]  rf_rd_o;
    logic [XLEN-1:0]   rf_rd_value_o;
    logic              rf_rd_write_o;
    logic              w_bypass_rd_write_o;
    logic [XLEN-1:0]   w_bypass_rd_value_o;

    modport slave (
        input  x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i,
               x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
        output w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o,
               w_bypass_rd_write_o, w_bypass_rd_value_o
    );

    modport master (
        output x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i,
               x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
        input  w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o,
               w_bypass_rd_write_o, w_bypass_rd_value_o
    );

endinterface

// File: rtl/rv_load_align.sv
// Combinational load data alignment and sign/zero extension.
// data     : raw 32-bit word from data memory
// addr     : low two bits of the load byte address
// fun      : load funct3
// result_c : aligned, extended register value (undefined funct3 -> full word)
module rv_load_align
    import rv_writeback_pkg::*;
(
    input  logic [XLEN-1:0]   data,
    input  logic [ALSB_W-1:0] addr,
    input  logic [FUN_W-1:0]  fun,
    output logic [XLEN-1:0]   result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[7:0];
        case (addr)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        // Halfword lane chosen by addr[1]; addr[0] is don't-care here
        half_sel = addr[1] ? data[31:16] : data[15:0];

        result_c = data;
        case (fun)
            FUN_LB:  result_c = {{24{byte_sel[7]}}, byte_sel};
            FUN_LH:  result_c = {{16{half_sel[15]}}, half_sel};
            FUN_LBU: result_c = {24'h0, byte_sel};
            FUN_LHU: result_c = {16'h0, half_sel};
            default: result_c = data;
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// uRV W stage: registers X results, waits for load completion, aligns load
// data and drives the regfile write port and the W->X bypass.
// clk_i, rst_i : clock, synchronous active-high reset
// wb (slave)   : X inputs, data-memory return, stall, regfile and bypass outputs
module rv_writeback
    import rv_writeback_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    rv_writeback_if.slave wb
);

    wb_state_e        state_q, state_d;
    x_entry_t         entry_q;
    logic             nonload_q;
    logic             capture_c;
    logic             stall_c;
    logic             wr_c;
    logic             strobe_c;
    logic [XLEN-1:0]  value_c;
    logic [XLEN-1:0]  aligned_c;

    rv_load_align u_align (
        .data     (wb.dm_data_l_i),
        .addr     (entry_q.addr),
        .fun      (entry_q.fun),
        .result_c (aligned_c)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Captured X payload; nonload_q marks a non-load result due for writeback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q   <= '0;
            nonload_q <= 1'b0;
        end else begin
            nonload_q <= capture_c && !wb.x_load_i;
            if (capture_c) begin
                entry_q.rd    <= wb.x_rd_i;
                entry_q.value <= wb.x_rd_value_i;
                entry_q.write <= wb.x_rd_write_i;
                entry_q.fun   <= wb.x_fun_i;
                entry_q.addr  <= wb.x_dm_addr_i;
            end
        end
    end

    // Next state, stall, write qualification and write data
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        wr_c    = 1'b0;
        value_c = entry_q.value;

        case (state_q)
            S_IDLE: begin
                wr_c = nonload_q;
            end
            S_WAIT_LOAD: begin
                if (wb.dm_load_done_i) begin
                    wr_c    = 1'b1;
                    value_c = aligned_c;
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A done arriving with reset is dropped along with the pending load
        if (rst_i) begin
            stall_c = 1'b0;
            wr_c    = 1'b0;
        end

        // Acceptance is allowed in the completing cycle: back-to-back loads
        capture_c = wb.x_valid_i && !stall_c && !rst_i;
        if (capture_c && wb.x_load_i) state_d = S_WAIT_LOAD;

        strobe_c = wr_c && entry_q.write && (entry_q.rd != '0);
    end

    assign wb.w_stall_o           = stall_c;
    assign wb.rf_rd_o             = entry_q.rd;
    assign wb.rf_rd_value_o       = value_c;
    assign wb.rf_rd_write_o       = strobe_c;
    assign wb.w_bypass_rd_write_o = strobe_c;
    assign wb.w_bypass_rd_value_o = value_c;

endmodule

// File: tb/tb_rv_writeback.sv
// Self-checking bench for rv_writeback: expected regfile writes are queued
// when an instruction is driven and popped when the write strobe appears.
module tb_rv_writeback;
    import rv_writeback_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_writeback_if bus();

    rv_writeback dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // Reference alignment written from byte lanes
    function automatic logic [31:0] model_align(input logic [31:0] d,
                                                input logic [2:0] f,
                                                input logic [1:0] a);
        logic [7:0]  lanes [4];
        logic [7:0]  b;
        logic [15:0] h;
        lanes[0] = d[7:0];
        lanes[1] = d[15:8];
        lanes[2] = d[23:16];
        lanes[3] = d[31:24];
        b = lanes[a];
        h = a[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        case (f)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // Scoreboard: every observed write must match the oldest expected one
    always @(negedge clk) begin
        if (mon_en && bus.rf_rd_write_o === 1'b1) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: write rd=%0d value=%08h, none expected",
                         bus.rf_rd_o, bus.rf_rd_value_o);
            end else begin
                e = exp_q.pop_front();
                n_checks += 3;
                if (bus.rf_rd_o !== e.rd) begin
                    n_fail++;
                    $display("FAIL sb_rd: got %0d expected %0d", bus.rf_rd_o, e.rd);
                end
                if (bus.rf_rd_value_o !== e.value) begin
                    n_fail++;
                    $display("FAIL sb_value: got %08h expected %08h", bus.rf_rd_value_o, e.value);
                end
                if (bus.w_bypass_rd_write_o !== 1'b1 || bus.w_bypass_rd_value_o !== e.value) begin
                    n_fail++;
                    $display("FAIL sb_bypass: got wr=%b val=%08h expected wr=1 val=%08h",
                             bus.w_bypass_rd_write_o, bus.w_bypass_rd_value_o, e.value);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_x();
        bus.x_valid_i    = 1'b0;
        bus.x_rd_i       = '0;
        bus.x_rd_value_i = '0;
        bus.x_rd_write_i = 1'b0;
        bus.x_load_i     = 1'b0;
        bus.x_fun_i      = '0;
        bus.x_dm_addr_i  = '0;
    endtask

    task automatic drive_x(input logic [4:0] rd, input logic [31:0] val, input logic wr,
                           input logic ld, input logic [2:0] fun, input logic [1:0] addr);
        bus.x_valid_i    = 1'b1;
        bus.x_rd_i       = rd;
        bus.x_rd_value_i = val;
        bus.x_rd_write_i = wr;
        bus.x_load_i     = ld;
        bus.x_fun_i      = fun;
        bus.x_dm_addr_i  = addr;
    endtask

    task automatic test_reset();
        clear_x();
        bus.dm_data_l_i    = '0;
        bus.dm_load_done_i = 1'b0;
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        n_checks += 4;
        if (bus.rf_rd_write_o !== 1'b0 || bus.w_bypass_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobe: got rf=%b byp=%b expected 0/0",
                     bus.rf_rd_write_o, bus.w_bypass_rd_write_o);
        end
        if (bus.w_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b expected 0", bus.w_stall_o);
        end
        if (bus.rf_rd_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_rd: got %0d expected 0", bus.rf_rd_o);
        end
        if (bus.rf_rd_value_o !== 32'h0 || bus.w_bypass_rd_value_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_value: got %08h/%08h expected 0",
                     bus.rf_rd_value_o, bus.w_bypass_rd_value_o);
        end
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_alu();
        drive_x(5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 2'd0);
        exp_q.push_back('{rd: 5'd5, value: 32'hDEADBEEF});
        step();
        clear_x();
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_strobe: got %b expected 1", bus.rf_rd_write_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0 || bus.w_bypass_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_strobe_drop: got %b/%b expected 0/0",
                     bus.rf_rd_write_o, bus.w_bypass_rd_write_o);
        end
        step();
    endtask

    task automatic test_rd0();
        drive_x(5'd0, 32'h1234, 1'b1, 1'b0, 3'd0, 2'd0);
        step();
        clear_x();
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0 || bus.w_bypass_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_alu: got %b/%b expected 0/0",
                     bus.rf_rd_write_o, bus.w_bypass_rd_write_o);
        end
        // Load to x0 still stalls until done, then writes nothing
        drive_x(5'd0, 32'h0, 1'b1, 1'b1, FUN_LW, 2'd0);
        step();
        clear_x();
        bus.dm_data_l_i = 32'h55AA55AA;
        @(negedge clk);
        n_checks++;
        if (bus.w_stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_load_stall: got %b expected 1", bus.w_stall_o);
        end
        step();
        bus.dm_load_done_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.w_stall_o !== 1'b0 || bus.rf_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_load_done: got stall=%b wr=%b expected 0/0",
                     bus.w_stall_o, bus.rf_rd_write_o);
        end
        step();
        bus.dm_load_done_i = 1'b0;
    endtask

    // Load with 'lat' stall cycles before done
    task automatic run_load(input logic [4:0] rd, input logic [2:0] fun, input logic [1:0] addr,
                            input logic [31:0] data, input int lat);
        drive_x(rd, 32'hBAD0BAD0, 1'b1, 1'b1, fun, addr);
        exp_q.push_back('{rd: rd, value: model_align(data, fun, addr)});
        step();
        clear_x();
        bus.dm_data_l_i = data;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.w_stall_o !== 1'b1 || bus.rf_rd_write_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load_wait rd=%0d cyc=%0d: got stall=%b wr=%b expected 1/0",
                         rd, c, bus.w_stall_o, bus.rf_rd_write_o);
            end
            step();
        end
        bus.dm_load_done_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.w_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_stall rd=%0d: got %b expected 0", rd, bus.w_stall_o);
        end
        step();
        bus.dm_load_done_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_strobe_drop rd=%0d: got %b expected 0", rd, bus.rf_rd_write_o);
        end
    endtask

    task automatic test_loads();
        run_load(5'd7, FUN_LB, 2'b11, 32'h80FFFF01, 2);
        run_load(5'd8, FUN_LHU, 2'b10, 32'h9ABC0000, 0);
        run_load(5'd9, FUN_LH, 2'b10, 32'h9ABC0000, 0);
        run_load(5'd10, FUN_LH, 2'b01, 32'h12348765, 1);
        run_load(5'd11, FUN_LBU, 2'b01, 32'h0000F200, 0);
        run_load(5'd12, FUN_LW, 2'b11, 32'hCAFEF00D, 1);
        run_load(5'd13, 3'b111, 2'b10, 32'h87654321, 0);
    endtask

    task automatic test_random_loads();
        logic [2:0] funs [7];
        funs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        for (int i = 0; i < 12; i++) begin
            run_load(5'(14 + i), funs[$urandom_range(0, 6)], 2'($urandom_range(0, 3)),
                     $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        // Load then ALU, done immediate: writes on consecutive cycles
        drive_x(5'd20, 32'h0, 1'b1, 1'b1, FUN_LW, 2'd0);
        exp_q.push_back('{rd: 5'd20, value: 32'hCAFEF00D});
        step();
        drive_x(5'd3, 32'h11, 1'b1, 1'b0, 3'd0, 2'd0);
        exp_q.push_back('{rd: 5'd3, value: 32'h11});
        bus.dm_data_l_i    = 32'hCAFEF00D;
        bus.dm_load_done_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b1 || bus.rf_rd_o !== 5'd20) begin
            n_fail++;
            $display("FAIL b2b_load_write: got wr=%b rd=%0d expected 1/20",
                     bus.rf_rd_write_o, bus.rf_rd_o);
        end
        step();
        clear_x();
        bus.dm_load_done_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b1 || bus.rf_rd_o !== 5'd3) begin
            n_fail++;
            $display("FAIL b2b_alu_write: got wr=%b rd=%0d expected 1/3",
                     bus.rf_rd_write_o, bus.rf_rd_o);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_dup: got %b expected 0", bus.rf_rd_write_o);
        end
        // Load with one stall cycle, ALU held by X across the stall
        drive_x(5'd21, 32'h0, 1'b1, 1'b1, FUN_LBU, 2'd2);
        exp_q.push_back('{rd: 5'd21, value: 32'h000000AB});
        step();
        drive_x(5'd4, 32'h22, 1'b1, 1'b0, 3'd0, 2'd0);
        exp_q.push_back('{rd: 5'd4, value: 32'h22});
        bus.dm_data_l_i = 32'h00AB0000;
        step();
        bus.dm_load_done_i = 1'b1;
        step();
        clear_x();
        bus.dm_load_done_i = 1'b0;
        // Two loads back to back, both completing immediately
        drive_x(5'd22, 32'h0, 1'b1, 1'b1, FUN_LB, 2'd0);
        exp_q.push_back('{rd: 5'd22, value: 32'hFFFFFF81});
        step();
        drive_x(5'd23, 32'h0, 1'b1, 1'b1, FUN_LH, 2'd0);
        exp_q.push_back('{rd: 5'd23, value: 32'hFFFF8181});
        bus.dm_data_l_i    = 32'h00008181;
        bus.dm_load_done_i = 1'b1;
        step();
        clear_x();
        @(negedge clk);
        n_checks++;
        if (bus.w_stall_o !== 1'b0 || bus.rf_rd_o !== 5'd23) begin
            n_fail++;
            $display("FAIL b2b_loads: got stall=%b rd=%0d expected 0/23",
                     bus.w_stall_o, bus.rf_rd_o);
        end
        step();
        bus.dm_load_done_i = 1'b0;
        step();
    endtask

    task automatic test_idle_done();
        bus.dm_load_done_i = 1'b1;
        bus.dm_data_l_i    = 32'hFFFFFFFF;
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0 || bus.w_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: got wr=%b stall=%b expected 0/0",
                     bus.rf_rd_write_o, bus.w_stall_o);
        end
        step();
        bus.dm_load_done_i = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        drive_x(5'd25, 32'h0, 1'b1, 1'b1, FUN_LW, 2'd0);
        step();
        clear_x();
        bus.dm_data_l_i = 32'h13579BDF;
        @(negedge clk);
        n_checks++;
        if (bus.w_stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstld_pre_stall: got %b expected 1", bus.w_stall_o);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.dm_load_done_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0 || bus.w_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstld_done: got wr=%b stall=%b expected 0/0",
                     bus.rf_rd_write_o, bus.w_stall_o);
        end
        step();
        bus.dm_load_done_i = 1'b0;
        // Done together with reset is also dropped
        drive_x(5'd26, 32'h0, 1'b1, 1'b1, FUN_LW, 2'd0);
        step();
        clear_x();
        rst = 1'b1;
        bus.dm_load_done_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rf_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstld_same_cycle: got %b expected 0", bus.rf_rd_write_o);
        end
        step();
        rst = 1'b0;
        bus.dm_load_done_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.w_stall_o !== 1'b0 || bus.rf_rd_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstld_idle: got stall=%b wr=%b expected 0/0",
                     bus.w_stall_o, bus.rf_rd_write_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_rd0();
        test_loads();
        test_random_loads();
        test_back_to_back();
        test_idle_done();
        test_reset_mid_load();
        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_writeback.md
Name: rv_writeback

Overview:
- W (writeback) stage of the uRV pipeline; sits between X (execute) and the register file write/bypass interface.
- Registers X results, waits for data-memory load completion, aligns and sign-extends load data, and drives the regfile write port plus the W→X bypass path.
- Stalls the pipeline while a load is outstanding.

Parameters:
- none (32-bit datapath, 5-bit register index fixed by ISA)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- x_valid_i  in  1  X presents an instruction result this cycle
- x_rd_i  in  5  destination register
- x_rd_value_i  in  32  ALU/CSR/jump-link result
- x_rd_write_i  in  1  instruction writes rd
- x_load_i  in  1  instruction is a load
- x_fun_i  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- x_dm_addr_i  in  2  low bits of load byte address
- dm_data_l_i  in  32  data-memory read word
- dm_load_done_i  in  1  load data valid this cycle
- w_stall_o  out  1  W cannot accept; upstream must hold
- rf_rd_o  out  5  regfile write address
- rf_rd_value_o  out  32  regfile write data
- rf_rd_write_o  out  1  regfile write strobe
- w_bypass_rd_write_o  out  1  bypass value valid for X
- w_bypass_rd_value_o  out  32  bypass value

Behaviour:
- One clock domain; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE; rf_rd_write_o=0; w_bypass_rd_write_o=0; w_stall_o=0; rf_rd_o=0; rf_rd_value_o=0; w_bypass_rd_value_o=0.
- States: IDLE (no pending load) and WAIT_LOAD.
- Capture: when x_valid_i=1 and w_stall_o=0, register rd, value, write, load, fun, addr on the rising edge.
- Non-load (IDLE, registered entry with write=1): in the following cycle assert rf_rd_write_o=1 for exactly one cycle, with rf_rd_value_o equal to the registered value. Bypass outputs mirror the write in the same cycle. Latency from X to regfile write is 1 cycle.
- Load captured: next state WAIT_LOAD. In WAIT_LOAD, w_stall_o = !dm_load_done_i (combinational).
- On the first cycle with dm_load_done_i=1:
  - rf_rd_write_o=1 and rf_rd_value_o=aligned data (combinational from dm_data_l_i).
  - Bypass outputs carry the same value.
  - State returns to IDLE on that edge.
- dm_load_done_i may be high in the first WAIT_LOAD cycle, giving zero extra stall.
- Alignment:
  - LB/LBU: byte addr[1:0]; LB sign-extends from bit 7, LBU zero-extends.
  - LH/LHU: halfword addr[1], addr[0] ignored; LH sign-extends from bit 15, LHU zero-extends.
  - LW and undefined funct3 codes: full word.
- rd=0: rf_rd_write_o and w_bypass_rd_write_o stay 0 even when write=1. A load to x0 still waits for dm_load_done_i.
- x_valid_i while w_stall_o=1 is ignored; X holds it until stall drops.
- In the cycle a load completes, W accepts a new X instruction; back-to-back loads lose no cycle.
- dm_load_done_i in IDLE is ignored (no write).
- Reset during WAIT_LOAD: return to IDLE, drop the pending write, and ignore a done in the same cycle.
- Write strobe and bypass are never asserted for more than one cycle per instruction.

Decomposition:
- rv_defs: load funct3 constants (LB, LH, LW, LBU, LHU).
- Sub-module rv_load_align: purely combinational (data, addr[1:0], fun) → 32-bit result; shared with future misaligned-trap logic.

Test Plan:
- ALU result: x_valid=1, rd=5, value=0xDEADBEEF, write=1 → next cycle rf_rd_write_o=1, rf_rd_o=5, rf_rd_value_o=0xDEADBEEF, bypass identical; strobe low the cycle after.
- rd=0: x_valid=1, rd=0, write=1, value=0x1234 → rf_rd_write_o and w_bypass_rd_write_o stay 0.
- LB with 3-cycle latency: x_load=1, fun=000, addr=2'b11, rd=7; dm_data=0x80FF_FF01, done asserted on the 3rd WAIT_LOAD cycle:
  - w_stall_o=1 for 2 cycles, then 0.
  - rf_rd_value_o=0xFFFFFF80, write in the done cycle.
- LHU/LH: addr=2'b10, dm_data=0x9ABC_0000 → LHU gives 0x00009ABC; LH gives 0xFFFF9ABC.
- Back-to-back: load (done immediate), then ALU rd=3 value=0x11 held during stall → two writes on consecutive cycles, no dropped or duplicated strobe.
- Reset mid-load: rst_i pulsed in WAIT_LOAD, dm_load_done_i=1 the next cycle → no rf write, w_stall_o=0, state IDLE.
